// File: rtl/lambda_argmax_if.sv
// lambda_argmax_if
//   Handshake/data bundle between the lambda pipeline (master side) and the
//   argmax search block (slave side).
//   Master drives : start, lambda_in, lambda_valid
//   Slave drives  : busy, theta_valid, theta_out, lambda_max_out
//   Parameters    : IDX_W (index / theta width), LAMBDA_W (lambda sample width)
interface lambda_argmax_if #(
  parameter int IDX_W    = 12,
  parameter int LAMBDA_W = 14
) ();
  logic                       start;
  logic signed [LAMBDA_W-1:0] lambda_in;
  logic                       lambda_valid;
  logic                       busy;
  logic                       theta_valid;
  logic        [IDX_W-1:0]    theta_out;
  logic signed [LAMBDA_W-1:0] lambda_max_out;

  modport master (
    output start, lambda_in, lambda_valid,
    input  busy, theta_valid, theta_out, lambda_max_out
  );

  modport slave (
    input  start, lambda_in, lambda_valid,
    output busy, theta_valid, theta_out, lambda_max_out
  );
endinterface

// File: rtl/lambda_argmax.sv
// lambda_argmax
//   Scans a window of SEARCH_LEN lambda samples (Q6.8 signed) and reports the
//   0-based index of the maximum (theta) together with the peak value.
//   Ties keep the first occurrence (strict greater-than compare).
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-high reset
//     bus  - lambda_argmax_if.slave:
//              start          one-cycle pulse arming a new search
//              lambda_in      lambda sample
//              lambda_valid   lambda_in valid this cycle
//              busy           high while searching
//              theta_valid    one-cycle pulse, results valid
//              theta_out      index of the maximum within the window
//              lambda_max_out peak lambda value
//
//   Optional feature macro: LAMBDA_ARGMAX_FREERUN_EN
//     When defined, the first start after reset puts the block in a free-running
//     mode: each window is followed immediately by the next one with no dead
//     cycle, busy stays high, and later start pulses are ignored.
//     When undefined, the block performs one search per start pulse.
module lambda_argmax #(
  parameter int SEARCH_LEN = 2192,
  parameter int IDX_W      = $clog2(SEARCH_LEN),
  parameter int LAMBDA_W   = 14
) (
  input  logic          clk,
  input  logic          rst,
  lambda_argmax_if.slave bus
);

  typedef logic signed [LAMBDA_W-1:0] lambda_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SEARCH_LEN - 1);
  localparam lambda_t          MOST_NEG = {1'b1, {(LAMBDA_W-1){1'b0}}};

  state_t             state_r;
  state_t             state_s;
  logic [IDX_W-1:0]   idx_r;
  lambda_t            max_r;
  logic [IDX_W-1:0]   arg_r;
  logic               busy_r;
  logic               busy_s;
  logic               theta_valid_r;
  logic [IDX_W-1:0]   theta_r;
  lambda_t            lmax_r;

  logic               consume_s;
  logic               last_s;
  logic               take_s;
  logic               arm_s;
  lambda_t            new_max_s;
  logic [IDX_W-1:0]   new_arg_s;

  // Sample consumption and running-max compare for the current sample
  always_comb begin
    consume_s = (state_r == SEARCH) && bus.lambda_valid;
    last_s    = (idx_r == LAST_IDX);
    // Index 0 always loads so the most-negative seed never leaks out.
    take_s    = (idx_r == IDX_ZERO) || (bus.lambda_in > max_r);
    // start is only honoured outside SEARCH; in free-run DONE is never
    // reached, so only the first start after reset (from IDLE) counts.
    arm_s     = bus.start && ((state_r == IDLE) || (state_r == DONE));
    if (take_s) begin
      new_max_s = bus.lambda_in;
      new_arg_s = idx_r;
    end else begin
      new_max_s = max_r;
      new_arg_s = arg_r;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_s = SEARCH;
        end else begin
          state_s = IDLE;
        end
      end
      SEARCH: begin
        if (consume_s && last_s) begin
`ifdef LAMBDA_ARGMAX_FREERUN_EN
          state_s = SEARCH;
`else
          state_s = DONE;
`endif
        end else begin
          state_s = SEARCH;
        end
      end
      DONE: begin
        if (bus.start) begin
          state_s = SEARCH;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM output decode; busy is registered from the next state so it lines up
  // with the state it describes
  always_comb begin
    if (state_s == SEARCH) begin
      busy_s = 1'b1;
    end else begin
      busy_s = 1'b0;
    end
  end

  // Search datapath: window index, running max and its index
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r <= IDX_ZERO;
      max_r <= MOST_NEG;
      arg_r <= IDX_ZERO;
    end else if (arm_s) begin
      idx_r <= IDX_ZERO;
      max_r <= MOST_NEG;
      arg_r <= IDX_ZERO;
    end else if (consume_s) begin
      if (last_s) begin
        // Window complete: results go to the output registers, search
        // registers are re-seeded so a free-running window starts clean.
        idx_r <= IDX_ZERO;
        max_r <= MOST_NEG;
        arg_r <= IDX_ZERO;
      end else begin
        idx_r <= idx_r + IDX_ONE;
        max_r <= new_max_s;
        arg_r <= new_arg_s;
      end
    end else begin
      idx_r <= idx_r;
      max_r <= max_r;
      arg_r <= arg_r;
    end
  end

  // Output registers: results captured in the cycle the last sample is consumed
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r        <= 1'b0;
      theta_valid_r <= 1'b0;
      theta_r       <= IDX_ZERO;
      lmax_r        <= '0;
    end else begin
      busy_r        <= busy_s;
      theta_valid_r <= consume_s && last_s;
      if (consume_s && last_s) begin
        theta_r <= new_arg_s;
        lmax_r  <= new_max_s;
      end else begin
        theta_r <= theta_r;
        lmax_r  <= lmax_r;
      end
    end
  end

  assign bus.busy           = busy_r;
  assign bus.theta_valid    = theta_valid_r;
  assign bus.theta_out      = theta_r;
  assign bus.lambda_max_out = lmax_r;

endmodule
